// File: rtl/mem_access_unit.sv
// MEM-stage data-bus initiator: issues loads/stores, waits for the response,
// aligns load data and presents the writeback record. Non-memory ops pass straight through.
module mem_access_unit #(
  parameter int unsigned     XLEN     = 64,
  parameter int unsigned     DST_W    = 5,
  parameter logic [XLEN-1:0] PC_RESET = 64'h8000_0000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ex_valid,
  input  logic [XLEN-1:0]  ex_pc,
  input  logic [XLEN-1:0]  ex_result,
  input  logic [XLEN-1:0]  ex_wdata,
  input  logic             ex_mem_rd,
  input  logic             ex_mem_wr,
  input  logic [1:0]       ex_size,
  input  logic             ex_unsigned,
  input  logic [DST_W-1:0] ex_dst,
  input  logic             ex_regwrite,
  input  logic             flush,
  output logic             stall,
  output logic             dreq_valid,
  output logic [XLEN-1:0]  dreq_addr,
  output logic [1:0]       dreq_size,
  output logic [7:0]       dreq_strobe,
  output logic [XLEN-1:0]  dreq_data,
  input  logic             dresp_ok,
  input  logic [XLEN-1:0]  dresp_data,
  output logic             wb_valid,
  output logic [XLEN-1:0]  wb_pc,
  output logic [XLEN-1:0]  wb_result,
  output logic [DST_W-1:0] wb_dst,
  output logic             wb_regwrite,
  output logic             wb_misalign,
  output logic             wb_bubble
);

  localparam int unsigned STRB_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } fsmState;

  fsmState state;
  fsmState nextState;

  logic              isMem;
  logic              aligned;
  logic              misalign;
  logic              issue;
  logic [STRB_W-1:0] strobeBase;
  logic [XLEN-1:0]   laneData;
  logic [XLEN-1:0]   shifted;
  logic [XLEN-1:0]   loadData;
  logic              signBit;

  logic [XLEN-1:0]   pcQ;
  logic [XLEN-1:0]   resultQ;
  logic [DST_W-1:0]  dstQ;
  logic              regwriteQ;
  logic              loadQ;
  logic              unsignedQ;
  logic              killQ;

  // Natural alignment check and request decode for the EX record
  always_comb begin
    aligned = 1'b1;
    case (ex_size)
      2'd0:    aligned = 1'b1;
      2'd1:    aligned = (ex_result[0] == 1'b0);
      2'd2:    aligned = (ex_result[1:0] == 2'b00);
      default: aligned = (ex_result[2:0] == 3'b000);
    endcase
  end

  assign isMem    = ex_mem_rd | ex_mem_wr;
  assign misalign = ex_valid & isMem & ~aligned;
  assign issue    = ex_valid & isMem & aligned & ~flush;

  // Byte-enable base pattern and lane-replicated store data
  always_comb begin
    strobeBase = 8'h01;
    laneData   = ex_wdata;
    case (ex_size)
      2'd0: begin
        strobeBase = 8'h01;
        laneData   = {8{ex_wdata[7:0]}};
      end
      2'd1: begin
        strobeBase = 8'h03;
        laneData   = {4{ex_wdata[15:0]}};
      end
      2'd2: begin
        strobeBase = 8'h0F;
        laneData   = {2{ex_wdata[31:0]}};
      end
      default: begin
        strobeBase = 8'hFF;
        laneData   = ex_wdata;
      end
    endcase
  end

  // Load data alignment uses the held request address/size
  assign shifted = dresp_data >> {dreq_addr[2:0], 3'b000};

  always_comb begin
    signBit  = 1'b0;
    loadData = shifted;
    case (dreq_size)
      2'd0: begin
        signBit  = ~unsignedQ & shifted[7];
        loadData = {{(XLEN-8){signBit}}, shifted[7:0]};
      end
      2'd1: begin
        signBit  = ~unsignedQ & shifted[15];
        loadData = {{(XLEN-16){signBit}}, shifted[15:0]};
      end
      2'd2: begin
        signBit  = ~unsignedQ & shifted[31];
        loadData = {{(XLEN-32){signBit}}, shifted[31:0]};
      end
      default: begin
        signBit  = 1'b0;
        loadData = shifted;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (issue) nextState = BUSY;
      BUSY:    if (dresp_ok) nextState = DONE;
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Writeback record and upstream stall; reset forces the idle record
  always_comb begin
    stall       = 1'b0;
    wb_valid    = 1'b0;
    wb_pc       = ex_pc;
    wb_result   = ex_result;
    wb_dst      = ex_dst;
    wb_regwrite = 1'b0;
    wb_misalign = 1'b0;
    if (!reset) begin
      wb_pc     = PC_RESET;
      wb_result = '0;
      wb_dst    = '0;
    end else begin
      case (state)
        IDLE: begin
          wb_misalign = misalign;
          if (issue) begin
            stall = 1'b1;
          end else begin
            wb_valid    = ex_valid & ~flush;
            wb_regwrite = ex_valid & ex_regwrite & ~flush & ~misalign;
          end
        end
        BUSY: begin
          stall = 1'b1;
        end
        DONE: begin
          wb_valid    = ~killQ & ~flush;
          wb_pc       = pcQ;
          wb_result   = resultQ;
          wb_dst      = dstQ;
          wb_regwrite = regwriteQ & ~killQ & ~flush;
        end
        default: begin
          stall = 1'b0;
        end
      endcase
    end
  end

  assign wb_bubble = ~wb_valid;

  // Request launch, response capture and sticky kill for flushes while busy
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dreq_valid  <= 1'b0;
      dreq_addr   <= '0;
      dreq_size   <= '0;
      dreq_strobe <= '0;
      dreq_data   <= '0;
      pcQ         <= '0;
      resultQ     <= '0;
      dstQ        <= '0;
      regwriteQ   <= 1'b0;
      loadQ       <= 1'b0;
      unsignedQ   <= 1'b0;
      killQ       <= 1'b0;
    end else begin
      if (state == IDLE && issue) begin
        dreq_valid  <= 1'b1;
        dreq_addr   <= ex_result;
        dreq_size   <= ex_size;
        dreq_strobe <= ex_mem_wr ? STRB_W'(strobeBase << ex_result[2:0]) : '0;
        dreq_data   <= laneData;
        pcQ         <= ex_pc;
        resultQ     <= ex_result;
        dstQ        <= ex_dst;
        regwriteQ   <= ex_regwrite;
        loadQ       <= ex_mem_rd;
        unsignedQ   <= ex_unsigned;
        killQ       <= 1'b0;
      end
      if (state == BUSY) begin
        if (flush) killQ <= 1'b1;
        if (dresp_ok) begin
          dreq_valid <= 1'b0;
          if (loadQ) resultQ <= loadData;
        end
      end
    end
  end

endmodule
